// File: rtl/c17_bist_pkg.sv
// Shared types, constants and step functions for the c17 BIST controller.
// Optional build macro: C17_BIST_EXHAUSTIVE_EN selects counter patterns.
package c17_bist_pkg;

    localparam int N_IN   = 5;
    localparam int N_OUT  = 2;
    localparam int MISR_W = 8;

    localparam logic [N_IN-1:0]   LFSR_POLY = 5'h12;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

`ifdef C17_BIST_EXHAUSTIVE_EN
    localparam int PATTERN_CNT = 1 << N_IN;
`else
    localparam int PATTERN_CNT = (1 << N_IN) - 1;
`endif

    localparam int CNT_W = $clog2(PATTERN_CNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [N_IN-1:0] lfsr_next(
        input logic [N_IN-1:0] s
    );
        logic [N_IN-1:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ LFSR_POLY;
        return r;
    endfunction

    function automatic logic [MISR_W-1:0] misr_step(
        input logic [MISR_W-1:0] m,
        input logic [N_OUT-1:0]  c
    );
        logic [MISR_W-1:0] r;
        r = {m[MISR_W-2:0], 1'b0};
        if (m[MISR_W-1]) r = r ^ MISR_POLY;
        return r ^ MISR_W'(c);
    endfunction

    function automatic logic [N_IN-1:0] pattern_seed(
        input logic [N_IN-1:0] s
    );
`ifdef C17_BIST_EXHAUSTIVE_EN
        return s;
`else
        return (s == '0) ? N_IN'(1) : s;
`endif
    endfunction

    function automatic logic [N_IN-1:0] pattern_next(
        input logic [N_IN-1:0] s
    );
`ifdef C17_BIST_EXHAUSTIVE_EN
        return s + 1'b1;
`else
        return lfsr_next(s);
`endif
    endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// Signature register compacting c17 responses.
// Clear wins over enable; reset is synchronous.
module c17_bist_misr
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [N_OUT-1:0]  din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;

    // Clear at run start, fold one response per enabled cycle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= misr_step(sig_q, din);
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17_bist_controller.sv
// BIST sequencer: pattern source, capture stage, FSM, result registers.
// Build macro C17_BIST_EXHAUSTIVE_EN swaps the LFSR for an up-counter.
module c17_bist_controller
    import c17_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [N_IN-1:0]   seed,
    input  logic [MISR_W-1:0] exp_sig,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic              pass
);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_OUT-1:0]  cap_q, cap_d;
    logic              cap_vld_q, cap_vld_d;
    logic [MISR_W-1:0] sig_q, sig_d;
    logic              pass_q, pass_d;
    logic              done_q, done_d;
    logic              misr_clr;
    logic              misr_en;
    logic [MISR_W-1:0] misr_sig;

    c17_bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (misr_clr),
        .en  (misr_en),
        .din (cap_q),
        .sig (misr_sig)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        cap_vld_d = cap_vld_q;
        sig_d     = sig_q;
        pass_d    = pass_q;
        done_d    = 1'b0;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SEED;
            end
            SEED: begin
                if (abort) begin
                    state_d = IDLE;
                    pat_d   = '0;
                end else begin
                    pat_d     = pattern_seed(seed);
                    misr_clr  = 1'b1;
                    cnt_d     = '0;
                    cap_vld_d = 1'b0;
                    pass_d    = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pat_d   = '0;
                end else begin
                    cap_d     = dut_out;
                    cap_vld_d = 1'b1;
                    misr_en   = cap_vld_q;
                    pat_d     = pattern_next(pat_q);
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(PATTERN_CNT - 1))
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    pat_d   = '0;
                end else begin
                    misr_en = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sig_d   = misr_sig;
                pass_d  = (misr_sig == exp_sig);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
            sig_q     <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            cap_vld_q <= cap_vld_d;
            sig_q     <= sig_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
        end
    end

    assign dut_in    = pat_q;
    assign busy      = (state_q == SEED) ||
                       (state_q == RUN)  ||
                       (state_q == DRAIN);
    assign done      = done_q;
    assign signature = sig_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_c17_bist_controller.sv
// Directed bench for c17_bist_controller with a local c17 netlist.
// Honours C17_BIST_EXHAUSTIVE_EN for pattern expectations.
module tb_c17_bist_controller;

    localparam int PC = c17_bist_pkg::PATTERN_CNT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] seed = '0;
    logic [7:0] exp_sig = '0;
    logic [4:0] dut_in;
    logic [1:0] dut_out;
    logic       busy;
    logic       done;
    logic [7:0] signature;
    logic       pass;

    int nerr = 0;
    int nchk = 0;

    int         r_lat;
    int         r_nd;
    logic [4:0] r_first [5];
    logic [4:0] r_last;
    logic [7:0] r_sig;
    logic       r_pass;
    logic       r_busy_ab;
    logic [4:0] r_din_ab;

    c17_bist_controller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .exp_sig   (exp_sig),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .pass      (pass)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] tb_c17(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    assign dut_out = tb_c17(dut_in);

    function automatic logic [4:0] tb_next(input logic [4:0] s);
        logic [4:0] r;
`ifdef C17_BIST_EXHAUSTIVE_EN
        r = s + 5'd1;
`else
        r[4] = s[0];
        r[3] = s[4];
        r[2] = s[3];
        r[1] = s[2] ^ s[0];
        r[0] = s[1];
`endif
        return r;
    endfunction

    function automatic logic [4:0] tb_fix(input logic [4:0] s);
`ifdef C17_BIST_EXHAUSTIVE_EN
        return s;
`else
        return (s == 5'd0) ? 5'd1 : s;
`endif
    endfunction

    function automatic logic [7:0] tb_misr(
        input logic [7:0] m,
        input logic [1:0] c
    );
        logic [7:0] r;
        r[0] = m[7] ^ c[0];
        r[1] = m[0] ^ c[1];
        r[2] = m[1] ^ m[7];
        r[3] = m[2] ^ m[7];
        r[4] = m[3] ^ m[7];
        r[5] = m[4];
        r[6] = m[5];
        r[7] = m[6];
        return r;
    endfunction

    function automatic logic [7:0] model_sig(input logic [4:0] s);
        logic [4:0] p;
        logic [7:0] m;
        p = tb_fix(s);
        m = '0;
        for (int i = 0; i < PC; i++) begin
            m = tb_misr(m, tb_c17(p));
            p = tb_next(p);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(
        input logic [4:0] s,
        input logic [7:0] e,
        input int         abort_at,
        input int         start_at
    );
        seed    = s;
        exp_sig = e;
        r_lat   = -1;
        r_nd    = 0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        for (int c = 2; c <= PC + 12; c++) begin
            if (c == abort_at) abort = 1'b1;
            if (c == start_at) start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (c == abort_at) begin
                r_busy_ab = busy;
                r_din_ab  = dut_in;
            end
            if (c >= 2 && c <= 6) r_first[c-2] = dut_in;
            if (c == PC + 2) r_last = dut_in;
            if (done) begin
                r_nd++;
                if (r_lat < 0) begin
                    r_lat  = c - 1;
                    r_sig  = signature;
                    r_pass = pass;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nchk++;
        if (dut_in !== 5'd0) begin
            nerr++;
            $display("FAIL reset_dut_in got=%h exp=00", dut_in);
        end
        nchk++;
        if ({busy, done, pass} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_flags got=%b exp=000",
                     {busy, done, pass});
        end
        nchk++;
        if (signature !== 8'd0) begin
            nerr++;
            $display("FAIL reset_sig got=%h exp=00", signature);
        end
        rst = 1'b0;
        tick();
        nchk++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_first [5];
        logic [7:0] g;
`ifdef C17_BIST_EXHAUSTIVE_EN
        exp_first = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
`else
        exp_first = '{5'h01, 5'h12, 5'h09, 5'h16, 5'h0B};
`endif
        g = model_sig(5'h01);
        do_run(5'h01, g, -1, -1);
        for (int i = 0; i < 5; i++) begin
            nchk++;
            if (r_first[i] !== exp_first[i]) begin
                nerr++;
                $display("FAIL seq_pat%0d got=%h exp=%h",
                         i, r_first[i], exp_first[i]);
            end
        end
        nchk++;
        if (r_last !== 5'h01) begin
            nerr++;
            $display("FAIL seq_wrap got=%h exp=01", r_last);
        end
        nchk++;
        if (r_lat !== PC + 3) begin
            nerr++;
            $display("FAIL seq_latency got=%0d exp=%0d",
                     r_lat, PC + 3);
        end
        nchk++;
        if (r_nd !== 1) begin
            nerr++;
            $display("FAIL seq_done_cnt got=%0d exp=1", r_nd);
        end
        nchk++;
        if (r_sig !== g) begin
            nerr++;
            $display("FAIL seq_sig got=%h exp=%h", r_sig, g);
        end
    endtask

    task automatic test_seed_zero();
        logic [4:0] f;
        logic [7:0] g;
`ifdef C17_BIST_EXHAUSTIVE_EN
        f = 5'h00;
`else
        f = 5'h01;
`endif
        g = model_sig(5'h00);
        do_run(5'h00, g, -1, -1);
        nchk++;
        if (r_first[0] !== f) begin
            nerr++;
            $display("FAIL seed0_first got=%h exp=%h", r_first[0], f);
        end
        nchk++;
        if (r_sig !== g) begin
            nerr++;
            $display("FAIL seed0_sig got=%h exp=%h", r_sig, g);
        end
        nchk++;
        if (r_lat !== PC + 3) begin
            nerr++;
            $display("FAIL seed0_latency got=%0d exp=%0d",
                     r_lat, PC + 3);
        end
    endtask

    task automatic test_pass();
        logic [7:0] g;
        g = model_sig(5'h0B);
        do_run(5'h0B, g, -1, -1);
        nchk++;
        if (r_pass !== 1'b1) begin
            nerr++;
            $display("FAIL pass_good got=%b exp=1", r_pass);
        end
        nchk++;
        if (signature !== g) begin
            nerr++;
            $display("FAIL pass_sig got=%h exp=%h", signature, g);
        end
        nchk++;
        if (pass !== 1'b1) begin
            nerr++;
            $display("FAIL pass_held got=%b exp=1", pass);
        end
        do_run(5'h0B, g ^ 8'h01, -1, -1);
        nchk++;
        if (r_pass !== 1'b0) begin
            nerr++;
            $display("FAIL pass_bad got=%b exp=0", r_pass);
        end
        nchk++;
        if (r_sig !== g) begin
            nerr++;
            $display("FAIL pass_bad_sig got=%h exp=%h", r_sig, g);
        end
    endtask

    task automatic test_abort();
        logic [7:0] prev;
        prev = model_sig(5'h0B);
        do_run(5'h13, 8'h00, 12, -1);
        nchk++;
        if (r_busy_ab !== 1'b0) begin
            nerr++;
            $display("FAIL abort_busy got=%b exp=0", r_busy_ab);
        end
        nchk++;
        if (r_din_ab !== 5'd0) begin
            nerr++;
            $display("FAIL abort_dut_in got=%h exp=00", r_din_ab);
        end
        nchk++;
        if (r_nd !== 0) begin
            nerr++;
            $display("FAIL abort_no_done got=%0d exp=0", r_nd);
        end
        nchk++;
        if (signature !== prev) begin
            nerr++;
            $display("FAIL abort_sig got=%h exp=%h", signature, prev);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] g;
        g = model_sig(5'h1C);
        do_run(5'h1C, g, -1, 15);
        nchk++;
        if (r_nd !== 1) begin
            nerr++;
            $display("FAIL restart_done_cnt got=%0d exp=1", r_nd);
        end
        nchk++;
        if (r_lat !== PC + 3) begin
            nerr++;
            $display("FAIL restart_latency got=%0d exp=%0d",
                     r_lat, PC + 3);
        end
        nchk++;
        if (r_sig !== g || r_pass !== 1'b1) begin
            nerr++;
            $display("FAIL restart_sig got=%h/%b exp=%h/1",
                     r_sig, r_pass, g);
        end
    endtask

    task automatic test_reset_drain();
        logic [7:0] g;
        seed  = 5'h07;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= PC + 2; c++) tick();
        nchk++;
        if (busy !== 1'b1 || signature === 8'd0) begin
            nerr++;
            $display("FAIL drain_pre got=%b/%h exp=1/nonzero",
                     busy, signature);
        end
        rst = 1'b1;
        tick();
        nchk++;
        if ({busy, done, pass} !== 3'b000 ||
            dut_in !== 5'd0 || signature !== 8'd0) begin
            nerr++;
            $display("FAIL drain_rst got=%b%b%b/%h/%h exp=000/00/00",
                     busy, done, pass, dut_in, signature);
        end
        rst = 1'b0;
        tick();
        g = model_sig(5'h07);
        do_run(5'h07, g, -1, -1);
        nchk++;
        if (r_lat !== PC + 3 || r_nd !== 1) begin
            nerr++;
            $display("FAIL drain_rerun got=%0d/%0d exp=%0d/1",
                     r_lat, r_nd, PC + 3);
        end
        nchk++;
        if (r_sig !== g || r_pass !== 1'b1) begin
            nerr++;
            $display("FAIL drain_rerun_sig got=%h/%b exp=%h/1",
                     r_sig, r_pass, g);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_seed_zero();
        test_pass();
        test_abort();
        test_start_ignored();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
